// File: rtl/multiport_register_file_pkg.sv
// CpuPkg: default register-file constants, FSM state type and port-bundle structs.
package CpuPkg;

  localparam int NUM_REGS_DEF = 32;
  localparam int DATA_W_DEF   = 32;
  localparam int NUM_RD_DEF   = 2;
  localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [NUM_RD_DEF-1:0][ADDR_W_DEF-1:0] addr;
  } rd_req_t;

  typedef struct packed {
    logic [NUM_RD_DEF-1:0][DATA_W_DEF-1:0] data;
    logic [NUM_RD_DEF-1:0]                 busy;
  } rd_rsp_t;

  typedef struct packed {
    logic                  en;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wr_req_t;

  typedef struct packed {
    logic                  en;
    logic [ADDR_W_DEF-1:0] addr;
  } alloc_req_t;

endpackage

// File: rtl/multiport_register_file_bank.sv
// regfile_bank: one-write / one-read register storage with a registered,
// read-first output so it maps onto block RAM.
module regfile_bank
  import CpuPkg::*;
#(
  parameter  int NUM_REGS = NUM_REGS_DEF,
  parameter  int DATA_W   = DATA_W_DEF,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  (* ram_style = "block" *) logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
    rdata_q <= mem_q[i_raddr];
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/multiport_register_file.sv
// multiport_register_file: replicated banks (one per read port), busy scoreboard
// and INIT-sweep FSM. Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module multiport_register_file
  import CpuPkg::*;
#(
  parameter  int NUM_REGS = NUM_REGS_DEF,
  parameter  int DATA_W   = DATA_W_DEF,
  parameter  int NUM_RD   = NUM_RD_DEF,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  output logic [NUM_RD-1:0]        o_rd_busy,
  input  logic                     i_wr_en,
  input  logic [ADDR_W-1:0]        i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic                     i_alloc_en,
  input  logic [ADDR_W-1:0]        i_alloc_addr,
  output logic                     o_ready
);

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        cnt_q, cnt_d;
  logic [NUM_REGS-1:0]      busy_q, busy_d;
  logic [NUM_RD-1:0]        rd_zero_q, rd_zero_d;
  logic [NUM_RD-1:0]        rd_busy_q, rd_busy_d;
  logic [NUM_RD-1:0][DATA_W-1:0] bank_rdata;
`ifdef REGFILE_BYPASS_EN
  logic [NUM_RD-1:0]             byp_q, byp_d;
  logic [NUM_RD-1:0][DATA_W-1:0] byp_data_q, byp_data_d;
`endif

  logic              run, wr_acc, alloc_acc, bank_we;
  logic [ADDR_W-1:0] bank_waddr;
  logic [DATA_W-1:0] bank_wdata;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q   <= ST_INIT;
      cnt_q     <= ADDR_W'(1);
      busy_q    <= '0;
      rd_zero_q <= '1;
      rd_busy_q <= '0;
`ifdef REGFILE_BYPASS_EN
      byp_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      rd_zero_q <= rd_zero_d;
      rd_busy_q <= rd_busy_d;
`ifdef REGFILE_BYPASS_EN
      byp_q     <= byp_d;
`endif
    end
  end

`ifdef REGFILE_BYPASS_EN
  always_ff @(posedge i_clk) byp_data_q <= byp_data_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + ADDR_W'(1);
      if (cnt_q == ADDR_W'(NUM_REGS - 1)) state_d = ST_RUN;
    end
  end

  // During INIT the shared bank write port is owned by the zeroing sweep.
  always_comb begin
    run        = (state_q == ST_RUN);
    o_ready    = run;
    wr_acc     = run && i_wr_en && (i_wr_addr != '0);
    alloc_acc  = run && i_alloc_en && (i_alloc_addr != '0);
    bank_we    = i_rst && (!run || wr_acc);
    bank_waddr = run ? i_wr_addr : cnt_q;
    bank_wdata = run ? i_wr_data : '0;
  end

  always_comb begin
    busy_d = busy_q;
    if (wr_acc)    busy_d[i_wr_addr]    = 1'b0;
    if (alloc_acc) busy_d[i_alloc_addr] = 1'b1;
    if (i_flush)   busy_d = '0;
  end

  always_comb begin
    logic [ADDR_W-1:0] a;
    rd_zero_d = '0;
    rd_busy_d = '0;
`ifdef REGFILE_BYPASS_EN
    byp_d      = '0;
    byp_data_d = '0;
`endif
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      a            = i_rd_addr[p*ADDR_W +: ADDR_W];
      rd_zero_d[p] = !run || (a == '0);
      rd_busy_d[p] = run && busy_q[a];
`ifdef REGFILE_BYPASS_EN
      if (wr_acc && (i_wr_addr == a)) begin
        byp_d[p]      = 1'b1;
        byp_data_d[p] = i_wr_data;
        rd_busy_d[p]  = alloc_acc && (i_alloc_addr == a);
      end
`endif
    end
  end

  always_comb begin
    o_rd_data = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      if (!rd_zero_q[p]) begin
`ifdef REGFILE_BYPASS_EN
        o_rd_data[p*DATA_W +: DATA_W] = byp_q[p] ? byp_data_q[p] : bank_rdata[p];
`else
        o_rd_data[p*DATA_W +: DATA_W] = bank_rdata[p];
`endif
      end
    end
    o_rd_busy = rd_busy_q;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_bank
    regfile_bank #(
      .NUM_REGS (NUM_REGS),
      .DATA_W   (DATA_W)
    ) u_bank (
      .i_clk   (i_clk),
      .i_we    (bank_we),
      .i_waddr (bank_waddr),
      .i_wdata (bank_wdata),
      .i_raddr (i_rd_addr[p*ADDR_W +: ADDR_W]),
      .o_rdata (bank_rdata[p])
    );
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// Randomised bench for multiport_register_file (default parameters) against an
// array-based reference model; honours REGFILE_BYPASS_EN for the expected results.
module tb_multiport_register_file;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        alloc_en;
  logic [4:0]  alloc_addr;
  logic        ready;

  multiport_register_file #(
    .NUM_REGS (32),
    .DATA_W   (32),
    .NUM_RD   (2)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_flush      (flush),
    .i_rd_addr    (rd_addr),
    .o_rd_data    (rd_data),
    .o_rd_busy    (rd_busy),
    .i_wr_en      (wr_en),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .i_alloc_en   (alloc_en),
    .i_alloc_addr (alloc_addr),
    .o_ready      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] m_mem  [32];
  logic        m_busy [32];
  bit          m_ready;
  int          m_idx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // One clock: predict outputs from the model, advance the model, then compare.
  task automatic cycle();
    logic [31:0] ed [2];
    logic        eb [2];
    int a;
    for (int p = 0; p < 2; p++) begin
      a = int'(rd_addr[p*5 +: 5]);
      ed[p] = 32'h0;
      eb[p] = 1'b0;
      if (rst && m_ready && a != 0) begin
        ed[p] = m_mem[a];
        eb[p] = m_busy[a];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && int'(wr_addr) == a) begin
          ed[p] = wr_data;
          eb[p] = alloc_en && int'(alloc_addr) == a;
        end
`endif
      end
    end
    @(posedge clk);
    if (!rst) begin
      m_ready = 1'b0;
      m_idx   = 1;
      for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
    end else if (!m_ready) begin
      m_mem[m_idx] = 32'h0;
      if (m_idx == 31) m_ready = 1'b1;
      else m_idx++;
    end else begin
      if (wr_en && wr_addr != 5'd0) begin
        m_mem[wr_addr]  = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (alloc_en && alloc_addr != 5'd0) m_busy[alloc_addr] = 1'b1;
      if (flush) for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
    end
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      check($sformatf("rd_data%0d", p), rd_data[p*32 +: 32], ed[p]);
      check($sformatf("rd_busy%0d", p), 32'(rd_busy[p]), 32'(eb[p]));
    end
    check("ready", 32'(ready), 32'(m_ready));
  endtask

  task automatic idle();
    rst      = 1'b1;
    flush    = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = 5'd0;
    wr_data  = 32'h0;
    alloc_en = 1'b0;
    alloc_addr = 5'd0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 100) begin
      cycle();
      n++;
    end
    check("init_cycles", 32'(n), 32'd31);
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      m_mem[r]  = 32'h0;
      m_busy[r] = 1'b0;
    end
    m_ready = 1'b0;
    m_idx   = 1;
    idle();
    rd_addr = 10'd0;
    rst = 1'b0;
    repeat (3) cycle();

    rst = 1'b1;
    wait_ready();
    for (int a = 1; a < 32; a++) begin
      rd_addr = {5'($urandom_range(0, 31)), 5'(a)};
      cycle();
    end

    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    cycle();
    idle();
    rd_addr = {5'd5, 5'd5};
    cycle();
    check("x5_p0", rd_data[31:0], 32'hDEADBEEF);
    check("x5_p1", rd_data[63:32], 32'hDEADBEEF);

    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
    alloc_en = 1'b1; alloc_addr = 5'd0;
    cycle();
    idle();
    rd_addr = {5'd0, 5'd0};
    cycle();
    check("x0_data", rd_data[31:0], 32'h0);
    check("x0_busy", 32'(rd_busy[0]), 32'h0);

    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1;
    cycle();
    wr_data = 32'hA5A5A5A5;
    rd_addr = {5'd7, 5'd7};
    cycle();
`ifdef REGFILE_BYPASS_EN
    check("x7_same_cycle", rd_data[31:0], 32'hA5A5A5A5);
`else
    check("x7_same_cycle", rd_data[31:0], 32'h1);
`endif
    idle();
    cycle();
    check("x7_after", rd_data[63:32], 32'hA5A5A5A5);

    alloc_en = 1'b1; alloc_addr = 5'd3;
    cycle();
    idle();
    rd_addr = {5'd3, 5'd3};
    cycle();
    check("x3_alloc_busy", 32'(rd_busy), 32'h3);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
    cycle();
    idle();
    cycle();
    check("x3_write_busy", 32'(rd_busy[0]), 32'h0);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h44;
    alloc_en = 1'b1; alloc_addr = 5'd3;
    cycle();
    idle();
    cycle();
    check("x3_both_busy", 32'(rd_busy[1]), 32'h1);
    flush = 1'b1;
    alloc_en = 1'b1; alloc_addr = 5'd4;
    cycle();
    idle();
    rd_addr = {5'd4, 5'd3};
    cycle();
    check("x3_flush_busy", 32'(rd_busy), 32'h0);
    check("x3_flush_data", rd_data[31:0], 32'h44);

    repeat (400) begin
      rd_addr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wr_en      = 1'($urandom_range(0, 1));
      wr_addr    = 5'($urandom_range(0, 7));
      wr_data    = $urandom;
      alloc_en   = ($urandom_range(0, 3) == 0);
      alloc_addr = 5'($urandom_range(0, 7));
      flush      = ($urandom_range(0, 19) == 0);
      cycle();
    end

    idle();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h55;
    cycle();
    idle();
    rd_addr = {5'd5, 5'd5};
    repeat (10) begin
      wr_en = 1'b1; wr_addr = 5'($urandom_range(1, 31)); wr_data = $urandom;
      cycle();
    end
    rst = 1'b0;
    repeat (2) cycle();
    check("ready_in_reset", 32'(ready), 32'h0);
    idle();
    wait_ready();
    rd_addr = {5'd5, 5'd5};
    cycle();
    check("x5_after_reset", rd_data[31:0], 32'h0);

    rst = 1'b0;
    cycle();
    rst = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    alloc_en = 1'b1; alloc_addr = 5'd9;
    repeat (5) cycle();
    idle();
    rst = 1'b0;
    cycle();
    idle();
    wait_ready();
    rd_addr = {5'd9, 5'd9};
    cycle();
    check("x9_init_write_ignored", rd_data[31:0], 32'h0);
    check("x9_init_alloc_ignored", 32'(rd_busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multiport_register_file.md
MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32: architectural register count, power of two, 2 to 64.
REQ-002 SHALL have parameter DATA_W, default 32: register width in bits.
REQ-003 SHALL have parameter NUM_RD, default 2: read port count, 1 to 4.
REQ-004 SHALL derive localparam ADDR_W = $clog2(NUM_REGS).
REQ-005 SHALL use one clock; reset is synchronous and active-low.
REQ-006 SHALL have port i_clk, input, 1: rising-edge clock.
REQ-007 SHALL have port i_rst, input, 1: synchronous, active-low reset.
REQ-008 SHALL have port i_flush, input, 1: clears all scoreboard busy bits.
REQ-009 SHALL have port i_rd_addr, input, NUM_RD x ADDR_W: read addresses.
REQ-010 SHALL have port o_rd_data, output, NUM_RD x DATA_W: registered read data.
REQ-011 SHALL have port o_rd_busy, output, NUM_RD: registered busy flag of each addressed register.
REQ-012 SHALL have port i_wr_en, input, 1: write strobe.
REQ-013 SHALL have ports i_wr_addr (input, ADDR_W) and i_wr_data (input, DATA_W): write address and data.
REQ-014 SHALL have ports i_alloc_en (input, 1) and i_alloc_addr (input, ADDR_W): mark destination register pending.
REQ-015 SHALL have port o_ready, output, 1: high once initialisation is complete.

Function
REQ-016 SHALL implement a two-state FSM: INIT, then RUN.
REQ-017 In INIT, SHALL write zero to one register per cycle at index 1..NUM_REGS-1 using a counter, entering RUN the cycle after index NUM_REGS-1 is written (NUM_REGS-1 cycles total).
REQ-018 In INIT, SHALL hold o_ready=0, ignore i_wr_en and i_alloc_en, and return o_rd_data=0 and o_rd_busy=0.
REQ-019 In RUN, SHALL hold o_ready=1.
REQ-020 Reads SHALL have exactly one cycle of latency: addresses sampled at edge N produce data valid after edge N.
REQ-021 Reads of address 0 SHALL return 0 and busy=0, regardless of any write or alloc to address 0.
REQ-022 Writes to address 0 SHALL be discarded, and allocs to address 0 SHALL be ignored.
REQ-023 Each write SHALL update every read bank in the same cycle.
REQ-024 An accepted write SHALL clear the busy bit of i_wr_addr.
REQ-025 An accepted alloc SHALL set the busy bit of i_alloc_addr.
REQ-026 If alloc and write target the same address in the same cycle, alloc SHALL win and the busy bit ends set.
REQ-027 i_flush SHALL clear all busy bits at the next edge, override a same-cycle alloc, and leave register data untouched.
REQ-028 Multiple read ports SHALL be allowed to read the same address in the same cycle, each getting identical results.

Reset
REQ-029 While i_rst=0 at a clock edge, SHALL set FSM=INIT, counter=1, all busy bits=0, o_rd_data=0, o_rd_busy=0, o_ready=0.
REQ-030 Reset asserted mid-RUN or mid-INIT SHALL restart the full INIT sequence; in-flight writes SHALL be dropped.
REQ-031 Register contents SHALL be defined only by the INIT sweep; storage is not required to have a reset net.

Configuration
REQ-032 With macro REGFILE_BYPASS_EN defined, a read of address A in the same cycle as an accepted write to A≠0 SHALL return i_wr_data and busy=0, unless an alloc to A occurs in the same cycle, in which case busy=1.
REQ-033 Without REGFILE_BYPASS_EN, the same-cycle read SHALL return the old stored value and the old busy bit; the new value becomes visible on the following read.

Structure
REQ-034 SHALL place the default constants and the port-bundle structs (read request/response arrays, write request, alloc request) in CpuPkg.
REQ-035 SHALL instantiate one sub-module, regfile_bank (1 write, 1 read, ram_style block), NUM_RD times; the scoreboard and FSM stay in the top level.

Verification
REQ-036 Scenario: release reset -> o_ready=0 for 31 cycles, then 1; reading x1..x31 after o_ready rises returns 0.
REQ-037 Scenario: write x5=0xDEADBEEF, then read x5 on both ports the next cycle -> 0xDEADBEEF on both ports one cycle later.
REQ-038 Scenario: write x0=0x1234, then read x0 -> 0.
REQ-039 Scenario: same-cycle write x7=0xA5A5A5A5 and read x7, with x7 holding 0x1 -> 0xA5A5A5A5 with REGFILE_BYPASS_EN defined, 0x1 without it.
REQ-040 Scenario: alloc x3, then read x3 -> busy=1; write x3 -> busy=0; alloc+write x3 in the same cycle -> busy=1; flush -> busy=0 and data retained.
REQ-041 Scenario: reset asserted 10 cycles into RUN after writes -> o_ready drops and a fresh 31-cycle INIT runs; x5 reads 0 afterwards.
